// File: rtl/rank_mr_responder.sv
// rank_mr_responder: per-rank engine that accepts MRW/MRR/PPR request edges,
// runs each op for a fixed latency and emits a one-cycle done pulse on expiry.
// Ports:
//   pclk_i, prst_i                    clock, async active-high reset
//   rank_mrw_i/rank_mrr_i/ppr_en_i    request levels per rank (rising edge = request)
//   ppr_fail_inj_i                    forces PPR fail; sampled when a PPR starts
//   mrw/mrr/ppr_done_status_o         one-cycle completion pulses
//   ppr_status_o                      1 = last PPR passed
//   busy_o                            engine active or request pending
//   ovf_o                             sticky: a request was dropped
module rank_mr_responder #(
  parameter int unsigned NB_RANK = 2,
  parameter int unsigned MRW_LAT = 4,
  parameter int unsigned MRR_LAT = 6,
  parameter int unsigned PPR_LAT = 16
) (
  input  logic               pclk_i,
  input  logic               prst_i,
  input  logic [NB_RANK-1:0] rank_mrw_i,
  input  logic [NB_RANK-1:0] rank_mrr_i,
  input  logic [NB_RANK-1:0] ppr_en_i,
  input  logic [NB_RANK-1:0] ppr_fail_inj_i,
  output logic [NB_RANK-1:0] mrw_done_status_o,
  output logic [NB_RANK-1:0] mrr_done_status_o,
  output logic [NB_RANK-1:0] ppr_done_status_o,
  output logic [NB_RANK-1:0] ppr_status_o,
  output logic [NB_RANK-1:0] busy_o,
  output logic [NB_RANK-1:0] ovf_o
);

  localparam int unsigned MAX_LAT_A = (MRW_LAT > MRR_LAT) ? MRW_LAT : MRR_LAT;
  localparam int unsigned MAX_LAT   = (PPR_LAT > MAX_LAT_A) ? PPR_LAT : MAX_LAT_A;
  localparam int unsigned CNT_W     = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  // Bit order for request/pending/done vectors: [2]=PPR, [1]=MRW, [0]=MRR
  localparam int unsigned OP_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MRW  = 2'd1,
    ST_MRR  = 2'd2,
    ST_PPR  = 2'd3
  } state_e;

  for (genvar r = 0; r < int'(NB_RANK); r++) begin : g_rank
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OP_W-1:0]   pend_q, pend_d;
    logic [OP_W-1:0]   prev_q, prev_d;
    logic [OP_W-1:0]   done_q, done_d;
    logic              stat_q, stat_d;
    logic              inj_q, inj_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic [OP_W-1:0]   req_v;
    logic [OP_W-1:0]   edge_v;
    logic              slot_free;
    logic              ppr_fin;

    assign req_v = {ppr_en_i[r], rank_mrw_i[r], rank_mrr_i[r]};

    // State and output registers
    always_ff @(posedge pclk_i or posedge prst_i) begin
      if (prst_i) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pend_q  <= '0;
        prev_q  <= '0;
        done_q  <= '0;
        stat_q  <= 1'b0;
        inj_q   <= 1'b0;
        ovf_q   <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pend_q  <= pend_d;
        prev_q  <= prev_d;
        done_q  <= done_d;
        stat_q  <= stat_d;
        inj_q   <= inj_d;
        ovf_q   <= ovf_d;
        busy_q  <= busy_d;
      end
    end

    // Next-state: edge detect, pending capture, expiry and priority launch
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      done_d    = '0;
      stat_d    = stat_q;
      inj_d     = inj_q;
      ovf_d     = ovf_q;
      busy_d    = busy_q;
      slot_free = 1'b0;
      ppr_fin   = 1'b0;
      prev_d    = req_v;

      edge_v = req_v & ~prev_q;
      // A request whose pending slot is already occupied is lost
      if (|(edge_v & pend_q)) begin
        ovf_d = 1'b1;
      end
      pend_d = pend_q | edge_v;

      if (state_q == ST_IDLE) begin
        slot_free = 1'b1;
      end else if (cnt_q == '0) begin
        slot_free = 1'b1;
        state_d   = ST_IDLE;
        case (state_q)
          ST_MRW: done_d[1] = 1'b1;
          ST_MRR: done_d[0] = 1'b1;
          ST_PPR: begin
            done_d[2] = 1'b1;
            stat_d    = ~inj_q;
            ppr_fin   = 1'b1;
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end

      if (slot_free) begin
        if (pend_d[2]) begin
          state_d   = ST_PPR;
          cnt_d     = CNT_W'(PPR_LAT - 1);
          pend_d[2] = 1'b0;
          inj_d     = ppr_fail_inj_i[r];
          // Back-to-back PPR: the finishing result stays visible with its pulse
          if (!ppr_fin) begin
            stat_d = 1'b0;
          end
        end else if (pend_d[1]) begin
          state_d   = ST_MRW;
          cnt_d     = CNT_W'(MRW_LAT - 1);
          pend_d[1] = 1'b0;
        end else if (pend_d[0]) begin
          state_d   = ST_MRR;
          cnt_d     = CNT_W'(MRR_LAT - 1);
          pend_d[0] = 1'b0;
        end
      end

      busy_d = (state_d != ST_IDLE) || (|pend_d);
    end

    assign ppr_done_status_o[r] = done_q[2];
    assign mrw_done_status_o[r] = done_q[1];
    assign mrr_done_status_o[r] = done_q[0];
    assign ppr_status_o[r]      = stat_q;
    assign busy_o[r]            = busy_q;
    assign ovf_o[r]             = ovf_q;
  end

endmodule

// File: tb/tb_rank_mr_responder.sv
// Testbench for rank_mr_responder: directed scenarios followed by random
// request traffic, all checked every cycle against a behavioural rank model.
module tb_rank_mr_responder;

  localparam int NB  = 2;
  localparam int LMW = 4;
  localparam int LMR = 6;
  localparam int LPP = 16;

  logic          pclk_i = 1'b0;
  logic          prst_i = 1'b0;
  logic [NB-1:0] rank_mrw_i = '0;
  logic [NB-1:0] rank_mrr_i = '0;
  logic [NB-1:0] ppr_en_i = '0;
  logic [NB-1:0] ppr_fail_inj_i = '0;
  logic [NB-1:0] mrw_done_status_o;
  logic [NB-1:0] mrr_done_status_o;
  logic [NB-1:0] ppr_done_status_o;
  logic [NB-1:0] ppr_status_o;
  logic [NB-1:0] busy_o;
  logic [NB-1:0] ovf_o;

  int n_assert = 0;
  int n_fail   = 0;

  rank_mr_responder #(
    .NB_RANK(NB), .MRW_LAT(LMW), .MRR_LAT(LMR), .PPR_LAT(LPP)
  ) dut (
    .pclk_i(pclk_i),
    .prst_i(prst_i),
    .rank_mrw_i(rank_mrw_i),
    .rank_mrr_i(rank_mrr_i),
    .ppr_en_i(ppr_en_i),
    .ppr_fail_inj_i(ppr_fail_inj_i),
    .mrw_done_status_o(mrw_done_status_o),
    .mrr_done_status_o(mrr_done_status_o),
    .ppr_done_status_o(ppr_done_status_o),
    .ppr_status_o(ppr_status_o),
    .busy_o(busy_o),
    .ovf_o(ovf_o)
  );

  always #5 pclk_i = ~pclk_i;

  // Reference model. Op index = priority rank: 0=PPR, 1=MRW, 2=MRR.
  // m_op = -1 when idle; m_rem = edges left until the op completes.
  int m_op   [NB];
  int m_rem  [NB];
  bit m_pend [NB][3];
  bit m_prev [NB][3];
  bit m_done [NB][3];
  bit m_stat [NB];
  bit m_inj  [NB];
  bit m_ovf  [NB];
  bit m_busy [NB];

  function automatic int lat_of(input int t);
    case (t)
      0:       return LPP;
      1:       return LMW;
      default: return LMR;
    endcase
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NB; r++) begin
      m_op[r] = -1; m_rem[r] = 0;
      m_stat[r] = 0; m_inj[r] = 0; m_ovf[r] = 0; m_busy[r] = 0;
      for (int t = 0; t < 3; t++) begin
        m_pend[r][t] = 0; m_prev[r][t] = 0; m_done[r][t] = 0;
      end
    end
  endtask

  // One clock edge of the model, using the inputs the DUT sees at that edge
  task automatic model_step();
    bit in_v [3];
    bit free, fin;
    if (prst_i) begin
      model_reset();
      return;
    end
    for (int r = 0; r < NB; r++) begin
      in_v[0] = ppr_en_i[r]; in_v[1] = rank_mrw_i[r]; in_v[2] = rank_mrr_i[r];
      for (int t = 0; t < 3; t++) begin
        m_done[r][t] = 0;
        if (in_v[t] && !m_prev[r][t]) begin
          if (m_pend[r][t]) m_ovf[r] = 1;
          else              m_pend[r][t] = 1;
        end
        m_prev[r][t] = in_v[t];
      end
      free = (m_op[r] < 0);
      fin  = 0;
      if (m_op[r] >= 0) begin
        if (m_rem[r] == 1) begin
          m_done[r][m_op[r]] = 1;
          if (m_op[r] == 0) begin
            m_stat[r] = !m_inj[r];
            fin = 1;
          end
          m_op[r] = -1;
          free = 1;
        end else begin
          m_rem[r]--;
        end
      end
      if (free) begin
        for (int t = 0; t < 3; t++) begin
          if (m_pend[r][t]) begin
            m_op[r] = t; m_rem[r] = lat_of(t); m_pend[r][t] = 0;
            if (t == 0) begin
              m_inj[r] = ppr_fail_inj_i[r];
              if (!fin) m_stat[r] = 0;
            end
            break;
          end
        end
      end
      m_busy[r] = (m_op[r] >= 0) || m_pend[r][0] || m_pend[r][1] || m_pend[r][2];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [NB-1:0] e_mw, e_mr, e_pp, e_st, e_bz, e_ov;
    for (int r = 0; r < NB; r++) begin
      e_pp[r] = m_done[r][0]; e_mw[r] = m_done[r][1]; e_mr[r] = m_done[r][2];
      e_st[r] = m_stat[r]; e_bz[r] = m_busy[r]; e_ov[r] = m_ovf[r];
    end
    chk("mrw_done", 32'(mrw_done_status_o), 32'(e_mw));
    chk("mrr_done", 32'(mrr_done_status_o), 32'(e_mr));
    chk("ppr_done", 32'(ppr_done_status_o), 32'(e_pp));
    chk("ppr_status", 32'(ppr_status_o), 32'(e_st));
    chk("busy", 32'(busy_o), 32'(e_bz));
    chk("ovf", 32'(ovf_o), 32'(e_ov));
  endtask

  task automatic tick();
    @(posedge pclk_i);
    model_step();
    #1;
    check_all();
  endtask

  int cnt;

  initial begin
    model_reset();

    // Reset with toggling requests: everything held at zero
    prst_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rank_mrw_i = 2'(k); rank_mrr_i = 2'(k + 1); ppr_en_i = 2'(~k);
      tick();
      chk("rst_busy", 32'(busy_o), 32'd0);
    end
    rank_mrw_i = '0; rank_mrr_i = '0; ppr_en_i = '0;
    tick();
    prst_i = 1'b0;
    tick();

    // Single MRW on rank 0: pulse only after edge N+MRW_LAT, rank 1 quiet
    rank_mrw_i[0] = 1'b1;
    for (int k = 0; k <= LMW + 2; k++) begin
      tick();
      rank_mrw_i[0] = 1'b0;
      chk("mrw0_pulse", 32'(mrw_done_status_o[0]), 32'(k == LMW));
      chk("rank1_quiet", 32'(busy_o[1]), 32'd0);
    end

    // Simultaneous MRW+MRR on rank 1: MRR chains behind MRW without a gap
    rank_mrw_i[1] = 1'b1; rank_mrr_i[1] = 1'b1;
    for (int k = 0; k <= LMW + LMR + 2; k++) begin
      tick();
      rank_mrw_i[1] = 1'b0; rank_mrr_i[1] = 1'b0;
      chk("mrw1_pulse", 32'(mrw_done_status_o[1]), 32'(k == LMW));
      chk("mrr1_pulse", 32'(mrr_done_status_o[1]), 32'(k == LMW + LMR));
      chk("busy1", 32'(busy_o[1]), 32'(k < LMW + LMR));
    end

    // PPR on rank 0 with fail injected, then again without
    for (int pass = 0; pass < 2; pass++) begin
      ppr_en_i[0] = 1'b1; ppr_fail_inj_i[0] = (pass == 0);
      for (int k = 0; k <= LPP + 1; k++) begin
        tick();
        ppr_en_i[0] = 1'b0; ppr_fail_inj_i[0] = 1'b0;
        chk("ppr0_pulse", 32'(ppr_done_status_o[0]), 32'(k == LPP));
        chk("ppr0_status", 32'(ppr_status_o[0]), 32'((k >= LPP) && (pass == 1)));
      end
    end

    // Repeated MRR edges while running: one queued, one dropped with overflow
    cnt = 0;
    for (int k = 0; k <= 2 * LMR + 4; k++) begin
      rank_mrr_i[0] = (k <= 4) && (k % 2 == 0);
      tick();
      if (mrr_done_status_o[0]) cnt++;
    end
    chk("mrr0_done_count", 32'(cnt), 32'd2);
    chk("ovf0_set", 32'(ovf_o[0]), 32'd1);
    tick();
    chk("ovf0_sticky", 32'(ovf_o[0]), 32'd1);

    // Reset in the middle of a PPR on rank 1: aborted, then fresh MRW works
    ppr_en_i[1] = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    ppr_en_i[1] = 1'b0;
    prst_i = 1'b1;
    tick();
    prst_i = 1'b0;
    cnt = 0;
    for (int k = 0; k < LPP + 2; k++) begin
      tick();
      if (ppr_done_status_o[1]) cnt++;
    end
    chk("ppr1_aborted", 32'(cnt), 32'd0);
    chk("busy_after_rst", 32'(busy_o), 32'd0);
    rank_mrw_i[1] = 1'b1;
    for (int k = 0; k <= LMW + 1; k++) begin
      tick();
      rank_mrw_i[1] = 1'b0;
      chk("mrw1_after_rst", 32'(mrw_done_status_o[1]), 32'(k == LMW));
    end

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      for (int r = 0; r < NB; r++) begin
        if ($urandom_range(0, 5) == 0) rank_mrw_i[r] = ~rank_mrw_i[r];
        if ($urandom_range(0, 5) == 0) rank_mrr_i[r] = ~rank_mrr_i[r];
        if ($urandom_range(0, 9) == 0) ppr_en_i[r]   = ~ppr_en_i[r];
        ppr_fail_inj_i[r] = 1'($urandom_range(0, 1));
      end
      prst_i = ($urandom_range(0, 399) == 0);
      tick();
    end
    prst_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
